// File: rtl/ram2e_cmd_seq.sv
// Unlock-key / command recogniser for RAMWorks bank-register writes.
// Emits one-shot qualifiers for the data write that follows a command byte.
module ram2e_cmd_seq #(
    parameter logic [7:0]      KEY0       = 8'hFF,
    parameter logic [7:0]      KEY1       = 8'h00,
    parameter logic [7:0]      KEY2       = 8'h55,
    parameter logic [7:0]      KEY3       = 8'hAA,
    parameter logic [7:0]      KEY4       = 8'hC1,
    parameter logic [7:0]      KEY5       = 8'hAD,
    parameter logic [7:0]      CMD_RWMASK = 8'h40,
    parameter logic [7:0]      CMD_LED    = 8'h41,
    parameter int              TO_W       = 12,
    parameter logic [TO_W-1:0] TO_CYC     = 12'hFFF
) (
    input  logic       C14M,
    input  logic       nRES,
    input  logic [3:0] S,
    input  logic       RWSel,
    input  logic [7:0] D,
    output logic [2:0] CS,
    output logic       CmdRWMaskSet,
    output logic       CmdLEDSet,
    output logic       CmdStrobe
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_K1   = 3'd1,
        ST_K2   = 3'd2,
        ST_K3   = 3'd3,
        ST_K4   = 3'd4,
        ST_K5   = 3'd5,
        ST_CMD  = 3'd6,
        ST_DATA = 3'd7
    } state_t;

    localparam logic [47:0] KEY_TAB = {KEY5, KEY4, KEY3, KEY2, KEY1, KEY0};

    state_t            cs_reg, cs_next;
    logic [TO_W-1:0]   timer_reg, timer_next;
    logic              rwmask_reg, rwmask_next;
    logic              led_reg, led_next;
    logic              strobe_reg, strobe_next;
    logic [7:0]        key_hit;
    logic              w;
    state_t            restart;

    // key_hit[k] says D matches the byte expected in state k; states 6/7 never match.
    for (genvar gi = 0; gi < 8; gi++) begin : g_key
        if (gi < 6) begin : g_cmp
            assign key_hit[gi] = (D == KEY_TAB[gi*8 +: 8]);
        end else begin : g_pad
            assign key_hit[gi] = 1'b0;
        end
    end

    assign w       = (S == 4'hC) && RWSel;
    assign restart = key_hit[0] ? ST_K1 : ST_IDLE;

    always_ff @(posedge C14M or negedge nRES) begin
        if (!nRES) begin
            cs_reg     <= ST_IDLE;
            timer_reg  <= '0;
            rwmask_reg <= 1'b0;
            led_reg    <= 1'b0;
            strobe_reg <= 1'b0;
        end else begin
            cs_reg     <= cs_next;
            timer_reg  <= timer_next;
            rwmask_reg <= rwmask_next;
            led_reg    <= led_next;
            strobe_reg <= strobe_next;
        end
    end

    always_comb begin
        cs_next     = cs_reg;
        timer_next  = timer_reg;
        rwmask_next = rwmask_reg;
        led_next    = led_reg;
        strobe_next = 1'b0;
        if (w) begin
            // A write always takes priority over a coincident timeout.
            timer_next = '0;
            case (cs_reg)
                ST_CMD: begin
                    cs_next     = ST_DATA;
                    strobe_next = 1'b1;
                    rwmask_next = (D == CMD_RWMASK);
                    led_next    = (D == CMD_LED);
                end
                ST_DATA: begin
                    cs_next     = restart;
                    rwmask_next = 1'b0;
                    led_next    = 1'b0;
                end
                default: begin
                    cs_next = key_hit[cs_reg] ? state_t'(cs_reg + 3'd1) : restart;
                end
            endcase
        end else if (cs_reg == ST_IDLE) begin
            timer_next = '0;
        end else if (timer_reg == TO_CYC) begin
            cs_next     = ST_IDLE;
            timer_next  = '0;
            rwmask_next = 1'b0;
            led_next    = 1'b0;
        end else if (S == 4'h0) begin
            timer_next = timer_reg + TO_W'(1);
        end
    end

    assign CS           = cs_reg;
    assign CmdRWMaskSet = rwmask_reg;
    assign CmdLEDSet    = led_reg;
    assign CmdStrobe    = strobe_reg;

endmodule
